// File: rtl/jump_pkg.sv
// Shared encodings for the jump/branch functional-unit sequencer:
// op codes, controller states and the FU compare codes.
package jump_pkg;

  typedef enum logic [1:0] {
    OP_BR   = 2'b00,
    OP_JAL  = 2'b01,
    OP_JALR = 2'b10,
    OP_ILL  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StRdop  = 3'd1,
    StExec  = 3'd2,
    StWb    = 3'd3,
    StDrain = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    CMP_EQ  = 3'b000,
    CMP_NE  = 3'b001,
    CMP_LT  = 3'b100,
    CMP_GE  = 3'b101,
    CMP_LTU = 3'b110,
    CMP_GEU = 3'b111
  } cmp_e;

  function automatic logic op_is_jump(op_e op);
    return (op == OP_JAL) || (op == OP_JALR);
  endfunction

endpackage

// File: rtl/jump_fu_ctrl.sv
// Single-op sequencer for the jump/branch FU: waits for operands, fires the FU,
// turns its result into a redirect and arbitrates the link-register writeback.
module jump_fu_ctrl
  import jump_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RAW  = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            issue_valid,
  output logic            issue_ready,
  input  logic [1:0]      issue_op,
  input  logic [2:0]      issue_cmp_ctrl,
  input  logic [RAW-1:0]  issue_rd,
  input  logic [RAW-1:0]  issue_rs1,
  input  logic [RAW-1:0]  issue_rs2,
  input  logic [XLEN-1:0] issue_imm,
  input  logic [XLEN-1:0] issue_pc,
  output logic [RAW-1:0]  src_rs1,
  output logic [RAW-1:0]  src_rs2,
  input  logic            rs1_ready,
  input  logic            rs2_ready,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            fu_en,
  output logic            fu_jalr,
  output logic [2:0]      fu_cmp_ctrl,
  output logic [XLEN-1:0] fu_rs1_data,
  output logic [XLEN-1:0] fu_rs2_data,
  output logic [XLEN-1:0] fu_imm,
  output logic [XLEN-1:0] fu_pc,
  input  logic            fu_finish,
  input  logic            fu_cmp_res,
  input  logic [XLEN-1:0] fu_pc_jump,
  input  logic [XLEN-1:0] fu_pc_wb,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            wb_req,
  input  logic            wb_grant,
  input  logic            war_clear,
  output logic [RAW-1:0]  wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            busy
);

  state_e          state_q, state_d;
  op_e             op_q, op_d;
  logic [2:0]      cmp_q, cmp_d;
  logic [RAW-1:0]  rd_q, rd_d;
  logic [RAW-1:0]  rs1_q, rs1_d;
  logic [RAW-1:0]  rs2_q, rs2_d;
  logic [XLEN-1:0] imm_q, imm_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] redir_pc_q, redir_pc_d;
  logic            redir_valid_q, redir_valid_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic [RAW-1:0]  wb_rd_q, wb_rd_d;

  logic need1, need2, wr, opnd_ok, taken;

  // Illegal ops behave as a branch that needs nothing and is never taken.
  assign need1   = (op_q == OP_BR) || (op_q == OP_JALR);
  assign need2   = (op_q == OP_BR);
  assign wr      = op_is_jump(op_q) && (rd_q != '0);
  assign opnd_ok = (~need1 | rs1_ready) & (~need2 | rs2_ready);
  assign taken   = op_is_jump(op_q) | ((op_q == OP_BR) & fu_cmp_res);

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    cmp_d         = cmp_q;
    rd_d          = rd_q;
    rs1_d         = rs1_q;
    rs2_d         = rs2_q;
    imm_d         = imm_q;
    pc_d          = pc_q;
    redir_pc_d    = redir_pc_q;
    redir_valid_d = 1'b0;
    wb_data_d     = wb_data_q;
    wb_rd_d       = wb_rd_q;
    fu_en         = 1'b0;
    wb_req        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (issue_valid && !flush) begin
          op_d    = op_e'(issue_op);
          cmp_d   = issue_cmp_ctrl;
          rd_d    = issue_rd;
          rs1_d   = issue_rs1;
          rs2_d   = issue_rs2;
          imm_d   = issue_imm;
          pc_d    = issue_pc;
          state_d = StRdop;
        end
      end
      StRdop: begin
        if (flush) begin
          state_d = StIdle;
        end else if (opnd_ok) begin
          fu_en   = 1'b1;
          state_d = StExec;
        end
      end
      StExec: begin
        if (flush) begin
          // An FU still running must be drained so its late finish is not mistaken.
          state_d = fu_finish ? StIdle : StDrain;
        end else if (fu_finish) begin
          if (taken) redir_pc_d = fu_pc_jump;
          redir_valid_d = taken;
          wb_data_d     = fu_pc_wb;
          wb_rd_d       = rd_q;
          state_d       = StWb;
        end
      end
      StWb: begin
        if (flush) begin
          state_d = StIdle;
        end else if (wr) begin
          wb_req = 1'b1;
          if (wb_grant && war_clear) state_d = StIdle;
        end else begin
          state_d = StIdle;
        end
      end
      StDrain: begin
        if (fu_finish) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      op_q          <= OP_BR;
      cmp_q         <= '0;
      rd_q          <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      imm_q         <= '0;
      pc_q          <= '0;
      redir_pc_q    <= '0;
      redir_valid_q <= 1'b0;
      wb_data_q     <= '0;
      wb_rd_q       <= '0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      cmp_q         <= cmp_d;
      rd_q          <= rd_d;
      rs1_q         <= rs1_d;
      rs2_q         <= rs2_d;
      imm_q         <= imm_d;
      pc_q          <= pc_d;
      redir_pc_q    <= redir_pc_d;
      redir_valid_q <= redir_valid_d;
      wb_data_q     <= wb_data_d;
      wb_rd_q       <= wb_rd_d;
    end
  end

  assign issue_ready    = (state_q == StIdle) & ~flush;
  assign busy           = (state_q != StIdle);
  assign src_rs1        = rs1_q;
  assign src_rs2        = rs2_q;
  assign fu_jalr        = (op_q == OP_JALR);
  assign fu_cmp_ctrl    = cmp_q;
  assign fu_imm         = imm_q;
  assign fu_pc          = pc_q;
  assign fu_rs1_data    = fu_en ? rs1_data : '0;
  assign fu_rs2_data    = fu_en ? rs2_data : '0;
  assign redirect_valid = redir_valid_q & ~flush;
  assign redirect_pc    = redir_pc_q;
  assign wb_rd          = wb_rd_q;
  assign wb_data        = wb_data_q;

endmodule

// File: tb/tb_jump_fu_ctrl.sv
// Bench for jump_fu_ctrl: hand-written vector table, randomized ops against a
// transaction-level model, plus flush/reset corner sequences.
module tb_jump_fu_ctrl;

  logic        clk = 1'b0;
  logic        rst, flush, issue_valid, issue_ready;
  logic [1:0]  issue_op;
  logic [2:0]  issue_cmp_ctrl;
  logic [4:0]  issue_rd, issue_rs1, issue_rs2;
  logic [31:0] issue_imm, issue_pc;
  logic [4:0]  src_rs1, src_rs2;
  logic        rs1_ready, rs2_ready;
  logic [31:0] rs1_data, rs2_data;
  logic        fu_en, fu_jalr;
  logic [2:0]  fu_cmp_ctrl;
  logic [31:0] fu_rs1_data, fu_rs2_data, fu_imm, fu_pc;
  logic        fu_finish, fu_cmp_res;
  logic [31:0] fu_pc_jump, fu_pc_wb;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        wb_req, wb_grant, war_clear;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        busy;

  jump_fu_ctrl #(.XLEN(32), .RAW(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_cmp_ctrl(issue_cmp_ctrl), .issue_rd(issue_rd), .issue_rs1(issue_rs1),
    .issue_rs2(issue_rs2), .issue_imm(issue_imm), .issue_pc(issue_pc),
    .src_rs1(src_rs1), .src_rs2(src_rs2), .rs1_ready(rs1_ready), .rs2_ready(rs2_ready),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .fu_en(fu_en), .fu_jalr(fu_jalr), .fu_cmp_ctrl(fu_cmp_ctrl),
    .fu_rs1_data(fu_rs1_data), .fu_rs2_data(fu_rs2_data), .fu_imm(fu_imm), .fu_pc(fu_pc),
    .fu_finish(fu_finish), .fu_cmp_res(fu_cmp_res), .fu_pc_jump(fu_pc_jump),
    .fu_pc_wb(fu_pc_wb), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .wb_req(wb_req), .wb_grant(wb_grant), .war_clear(war_clear), .wb_rd(wb_rd),
    .wb_data(wb_data), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [2:0]  cmp;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] pc, imm, jump, wbv;
    logic        cmp_res;
    int          d1, d2, g;  // cycles rs1/rs2 stay not-ready; WB cycles war_clear stays low
  } txn_t;

  typedef struct {
    int lat;     // accept cycle -> first cycle issue_ready is high again
    int wait_c;  // operand stall cycles before fu_en
    bit taken;
    bit wr;
  } exp_t;

  typedef struct {
    string name;
    txn_t  t;
    exp_t  e;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic txn_t mk(input logic [1:0] op, input logic [2:0] cmp, input logic [4:0] rd,
                              input logic [31:0] pc, input logic [31:0] imm,
                              input logic [31:0] jump, input logic [31:0] wbv,
                              input logic cmp_res, input int d1, input int d2, input int g);
    txn_t t;
    t.op = op; t.cmp = cmp; t.rd = rd; t.rs1 = rd ^ 5'h11; t.rs2 = rd ^ 5'h0a;
    t.pc = pc; t.imm = imm; t.jump = jump; t.wbv = wbv; t.cmp_res = cmp_res;
    t.d1 = d1; t.d2 = d2; t.g = g;
    return t;
  endfunction

  // Reference: op semantics and cycle budget derived directly from the op rules.
  function automatic exp_t model(input txn_t t);
    exp_t e;
    bit   is_br, is_jmp;
    int   w1, w2;
    is_br    = (t.op == 2'b00);
    is_jmp   = (t.op == 2'b01) || (t.op == 2'b10);
    w1       = (is_br || t.op == 2'b10) ? t.d1 : 0;
    w2       = is_br ? t.d2 : 0;
    e.wait_c = (w1 > w2) ? w1 : w2;
    e.taken  = is_jmp || (is_br && (t.cmp_res === 1'b1));
    e.wr     = is_jmp && (t.rd != 5'd0);
    e.lat    = 4 + e.wait_c + (e.wr ? t.g : 0);
    return e;
  endfunction

  task automatic idle_inputs();
    flush = 0; issue_valid = 0; issue_op = 0; issue_cmp_ctrl = 0;
    issue_rd = 0; issue_rs1 = 0; issue_rs2 = 0; issue_imm = 0; issue_pc = 0;
    rs1_ready = 1; rs2_ready = 1; rs1_data = 0; rs2_data = 0;
    fu_finish = 0; fu_cmp_res = 0; fu_pc_jump = 0; fu_pc_wb = 0;
    wb_grant = 1; war_clear = 1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic issue(input txn_t t);
    issue_valid = 1; issue_op = t.op; issue_cmp_ctrl = t.cmp; issue_rd = t.rd;
    issue_rs1 = t.rs1; issue_rs2 = t.rs2; issue_imm = t.imm; issue_pc = t.pc;
  endtask

  task automatic run_txn(input string tag, input txn_t t, input exp_t e);
    int   en_cnt, en_at, redir_cnt, req_cnt, lat;
    bit   prev_en, en_b2b, jalr_ok, opnd_ok, wb_ok;
    logic [31:0] rpc;
    en_cnt = 0; en_at = -1; redir_cnt = 0; req_cnt = 0; lat = -1;
    prev_en = 0; en_b2b = 0; jalr_ok = 1; opnd_ok = 1; wb_ok = 0; rpc = 0;
    @(posedge clk); #1;
    issue(t);
    rs1_data = t.pc ^ 32'h5a5a_0000; rs2_data = ~t.imm;
    fu_finish = 0;
    @(negedge clk);
    chk({tag, "/accept_ready"}, issue_ready, 1);
    for (int c = 1; c <= 60 && lat < 0; c++) begin
      @(posedge clk); #1;
      issue_valid = 0;
      issue_op = 2'($urandom); issue_rd = 5'($urandom); issue_pc = $urandom;
      issue_imm = $urandom; issue_cmp_ctrl = 3'($urandom);
      rs1_ready  = (c > t.d1);
      rs2_ready  = (c > t.d2);
      fu_finish  = prev_en;
      fu_cmp_res = t.cmp_res;
      fu_pc_jump = t.jump;
      fu_pc_wb   = t.wbv;
      wb_grant   = 1;
      war_clear  = (req_cnt >= t.g);
      @(negedge clk);
      if (fu_en) begin
        en_cnt++;
        if (prev_en) en_b2b = 1;
        en_at = c;
        if (fu_rs1_data !== rs1_data || fu_rs2_data !== rs2_data || fu_pc !== t.pc ||
            fu_imm !== t.imm || fu_cmp_ctrl !== t.cmp || src_rs1 !== t.rs1 ||
            src_rs2 !== t.rs2)
          opnd_ok = 0;
      end
      if ((fu_en || fu_finish) && fu_jalr !== (t.op == 2'b10)) jalr_ok = 0;
      if (redirect_valid) begin
        redir_cnt++;
        rpc = redirect_pc;
      end
      if (wb_req) begin
        req_cnt++;
        if (war_clear && wb_grant) wb_ok = (wb_rd === t.rd) && (wb_data === t.wbv);
      end
      if (issue_ready) lat = c;
      prev_en = fu_en;
    end
    fu_finish = 0;
    chk({tag, "/latency"}, lat, e.lat);
    chk({tag, "/fu_en_count"}, en_cnt, 1);
    chk({tag, "/fu_en_cycle"}, en_at, 1 + e.wait_c);
    chk({tag, "/fu_en_b2b"}, en_b2b, 0);
    chk({tag, "/fu_operands"}, opnd_ok, 1);
    chk({tag, "/fu_jalr"}, jalr_ok, 1);
    chk({tag, "/redirect_count"}, redir_cnt, e.taken ? 1 : 0);
    if (e.taken) chk({tag, "/redirect_pc"}, rpc, t.jump);
    chk({tag, "/wb_req_cycles"}, req_cnt, e.wr ? t.g + 1 : 0);
    if (e.wr) chk({tag, "/wb_rd_data"}, wb_ok, 1);
    if (lat < 0) do_reset();
  endtask

  vec_t vt[7];

  initial begin
    txn_t t;
    idle_inputs();
    rst = 1;

    // Expectations hand-derived from the op rules and the 4-cycle minimum.
    vt[0] = '{"jal_link",   mk(2'b01, 3'b000, 5'd1, 32'h100, 32'h20, 32'h120, 32'h104, 0, 0, 0, 0),
              '{4, 0, 1, 1}};
    vt[1] = '{"beq_stall",  mk(2'b00, 3'b000, 5'd7, 32'h200, 32'h40, 32'h240, 32'h204, 0, 3, 0, 0),
              '{7, 3, 0, 0}};
    vt[2] = '{"jalr_rd0",   mk(2'b10, 3'b000, 5'd0, 32'h300, 32'h8, 32'h1234, 32'h304, 1'bx, 0, 0, 0),
              '{4, 0, 1, 0}};
    vt[3] = '{"jal_war",    mk(2'b01, 3'b000, 5'd5, 32'h400, 32'h10, 32'h410, 32'h404, 0, 0, 0, 2),
              '{6, 0, 1, 1}};
    vt[4] = '{"illegal",    mk(2'b11, 3'b001, 5'd4, 32'h500, 32'h4, 32'h504, 32'h504, 1, 2, 2, 0),
              '{4, 0, 0, 0}};
    vt[5] = '{"bne_taken",  mk(2'b00, 3'b001, 5'd3, 32'h600, 32'h80, 32'h680, 32'h604, 1, 1, 2, 0),
              '{6, 2, 1, 0}};
    vt[6] = '{"jalr_stall", mk(2'b10, 3'b000, 5'd9, 32'h700, 32'hc, 32'h8000, 32'h704, 0, 2, 0, 1),
              '{7, 2, 1, 1}};

    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("reset/issue_ready", issue_ready, 1);
    chk("reset/busy", busy, 0);
    chk("reset/outputs", {fu_en, redirect_valid, wb_req, fu_jalr}, 0);
    chk("reset/data", wb_data | redirect_pc | fu_pc | fu_imm, 0);

    foreach (vt[i]) run_txn(vt[i].name, vt[i].t, vt[i].e);

    for (int i = 0; i < 40; i++) begin
      t = mk(2'($urandom_range(0, 3)), 3'($urandom),
             ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
             $urandom, $urandom, $urandom, $urandom, 1'($urandom),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      run_txn($sformatf("rand%0d", i), t, model(t));
    end

    // flush while idle blocks the issue
    @(posedge clk); #1;
    t = mk(2'b01, 3'b000, 5'd1, 32'h900, 32'h4, 32'h904, 32'h904, 0, 0, 0, 0);
    issue(t);
    flush = 1;
    @(negedge clk);
    chk("flush_idle/issue_ready", issue_ready, 0);
    @(posedge clk); #1;
    issue_valid = 0; flush = 0;
    @(negedge clk);
    chk("flush_idle/not_accepted", busy, 0);

    // flush in EXEC before finish: drain the late finish, discard results
    @(posedge clk); #1;
    issue(t);
    @(posedge clk); #1;
    issue_valid = 0;
    fu_pc_jump = 32'hdead_0000; fu_pc_wb = 32'hbeef_0000; fu_cmp_res = 1;
    @(negedge clk);
    chk("flush_exec/fu_en", fu_en, 1);
    @(posedge clk); #1;
    flush = 1; fu_finish = 0;
    @(negedge clk);
    chk("flush_exec/issue_ready", issue_ready, 0);
    @(posedge clk); #1;
    flush = 0; fu_finish = 1;
    @(negedge clk);
    chk("drain/busy", busy, 1);
    chk("drain/quiet", {issue_ready, redirect_valid, wb_req, fu_en}, 0);
    @(posedge clk); #1;
    fu_finish = 0;
    @(negedge clk);
    chk("drain/issue_ready", issue_ready, 1);
    chk("drain/no_result", {redirect_valid, wb_req}, 0);

    // reset while WB is requesting
    @(posedge clk); #1;
    t = mk(2'b01, 3'b000, 5'd5, 32'ha00, 32'h4, 32'ha04, 32'ha04, 0, 0, 0, 0);
    issue(t);
    war_clear = 0;
    @(posedge clk); #1;
    issue_valid = 0;
    @(posedge clk); #1;
    fu_finish = 1; fu_pc_jump = 32'ha04; fu_pc_wb = 32'ha04;
    @(posedge clk); #1;
    fu_finish = 0; rst = 1;
    @(negedge clk);
    chk("rst_wb/wb_req_before", wb_req, 1);
    @(posedge clk); #1;
    rst = 0; war_clear = 1;
    @(negedge clk);
    chk("rst_wb/issue_ready", issue_ready, 1);
    chk("rst_wb/ctrl", {busy, fu_en, redirect_valid, wb_req, fu_jalr}, 0);
    chk("rst_wb/data", wb_data | redirect_pc | fu_pc | fu_imm | {27'd0, wb_rd}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/jump_fu_ctrl.md
Name: jump_fu_ctrl

Overview:
- Scoreboard-style sequencer for the single jump/branch functional unit.
- Accepts one BR/JAL/JALR op from issue and waits for its source operands.
- Fires the FU with a one-cycle enable pulse, captures its results, and produces a redirect.
- Arbitrates the link-register writeback and releases the unit; only one op is in flight.

Parameters:
- XLEN, 32, datapath width.
- RAW, 5, register-address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  kill the op in flight.
- issue_valid  in  1  issue request.
- issue_ready  out  1  controller can accept an op.
- issue_op  in  2  00 BR, 01 JAL, 10 JALR, 11 illegal.
- issue_cmp_ctrl  in  3  branch compare code.
- issue_rd, issue_rs1, issue_rs2  in  RAW  register indices.
- issue_imm, issue_pc  in  XLEN  immediate and PC.
- src_rs1, src_rs2  out  RAW  latched source indices to the scoreboard/RF.
- rs1_ready, rs2_ready  in  1  no pending writer for src_rs1 / src_rs2.
- rs1_data, rs2_data  in  XLEN  RF read data.
- fu_en  out  1  FU start pulse.
- fu_jalr  out  1  FU JALR select.
- fu_cmp_ctrl  out  3  FU compare code.
- fu_rs1_data, fu_rs2_data, fu_imm, fu_pc  out  XLEN  FU operands.
- fu_finish  in  1  FU done, one cycle after fu_en.
- fu_cmp_res  in  1  FU compare result.
- fu_pc_jump, fu_pc_wb  in  XLEN  FU target and link value.
- redirect_valid  out  1  one-cycle pulse.
- redirect_pc  out  XLEN  redirect target.
- wb_req  out  1  writeback request.
- wb_grant  in  1  writeback granted.
- war_clear  in  1  no earlier reader of wb_rd is outstanding.
- wb_rd  out  RAW  writeback register.
- wb_data  out  XLEN  writeback data.
- busy  out  1  state != IDLE.

Behaviour:
- States: IDLE, RDOP, EXEC, WB, DRAIN.
- Reset (rst sampled at a clock edge): state=IDLE and all registered fields = 0. Outputs: issue_ready=1; fu_en, redirect_valid, wb_req, busy = 0; all data outputs = 0.
- issue_ready = (state==IDLE) & ~flush.
- Decode per op:
  - need1 = (op!=JAL); need2 = (op==BR).
  - wr = (op!=BR) & (rd!=0).
  - op 11 is accepted and treated as BR with need1=need2=0 and a never-taken result.
- IDLE:
  - Accept when issue_valid & issue_ready: latch all issue fields, go to RDOP.
- RDOP:
  - When (~need1|rs1_ready) & (~need2|rs2_ready), assert fu_en combinationally for exactly that cycle.
  - In the same cycle, drive fu_rs1_data/fu_rs2_data from rs1_data/rs2_data (unneeded operands are don't-care), then go to EXEC.
  - Otherwise hold in RDOP.
- fu_jalr, fu_cmp_ctrl, fu_imm and fu_pc are driven from latched fields and held stable from RDOP through the EXEC cycle in which fu_finish=1, because the FU selects its target with the live jalr input.
- fu_en is never asserted outside RDOP, and never on two consecutive cycles.
- EXEC:
  - Wait for fu_finish.
  - On fu_finish, compute taken = (op!=BR) | (op==BR & fu_cmp_res).
  - If taken, latch redirect_pc = fu_pc_jump. Always latch wb_data = fu_pc_wb and wb_rd.
  - Go to WB; redirect_valid is registered high for the first WB cycle only, and only if taken.
- WB:
  - If wr: wb_req=1 until wb_grant & war_clear are both high in the same cycle, then IDLE.
  - If ~wr: leave after one cycle, to IDLE.
- Latency with operands ready: issue edge → fu_en in the following cycle → fu_finish next → redirect_valid next → IDLE after grant. Minimum four cycles from issue accept to issue_ready.
- flush:
  - Has priority over all other transitions.
  - IDLE/RDOP/WB → IDLE. wb_req and redirect_valid are suppressed that cycle and the issue is not accepted.
  - EXEC with fu_finish=0 → DRAIN. DRAIN waits for fu_finish, discards the results, then goes to IDLE.
  - EXEC with fu_finish=1 → IDLE, results discarded.
- rst mid-operation: IDLE immediately. The FU is assumed to self-return to idle within one cycle.
- A stuck fu_finish is not detected; a watchdog is out of scope.

Decomposition:
- Shared package jump_pkg: op encodings (OP_BR/OP_JAL/OP_JALR), state encoding, and the cmp_ctrl code constants used by the FU compare unit.
- No sub-module needed; operand readiness and decode stay inline.

Test Plan:
- JAL, rd=1, pc=0x100, imm=0x20, FU returns jump=0x120 and wb=0x104 → fu_en once in the cycle after accept; redirect_pc=0x120; with wb_grant=war_clear=1, wb_rd=1 and wb_data=0x104; issue_ready again 4 cycles after accept.
- BEQ with rs1_ready=0 for 3 cycles, fu_cmp_res=0 → fu_en held low for 3 cycles then one pulse; no redirect_valid; no wb_req; return to IDLE.
- JALR, rd=0, fu_cmp_res=x → redirect to fu_pc_jump; wb_req never asserted; fu_jalr=1 held through the finish cycle.
- JAL, rd=5, with wb_grant=1 but war_clear=0 for 2 cycles → wb_req held; release in the cycle both are high.
- flush in the EXEC cycle before fu_finish → DRAIN; finish consumed; no redirect or writeback; issue_ready returns one cycle after finish.
- rst asserted while in WB with wb_req=1 → the next cycle has all outputs at reset values and issue_ready=1.
